exhaustive_stim_checker: RTL and testbench
==========================================

Name: exhaustive_stim_checker

Overview:
Self-checking stimulus and response stage that sits around a combinational or pipelined arithmetic/logic DUT, such as the generated gates and adders.
- Upstream role: drives every 2-operand input vector exhaustively into the DUT.
- Downstream role: compares the DUT output against a golden-model output on the same vector, counts mismatches and captures the first failing vector.
- Replaces free-running toggle stimulus with a deterministic, synthesizable sweep usable both in simulation and on FPGA.

Parameters:
WIDTH, 1, bit width of each operand _a/_b; legal range 1..12
OUT_W, 1, bit width of DUT/reference outputs
LATENCY, 0, DUT pipeline depth in clock cycles (0 = combinational DUT); legal range 0..15

Ports:
_clk  in  1  rising-edge clock
_rst_n  in  1  asynchronous active-low reset
_start  in  1  sweep request, sampled on rising edge
_a  out  WIDTH  operand A to DUT and reference model
_b  out  WIDTH  operand B to DUT and reference model
_dut_y  in  OUT_W  DUT output
_ref_y  in  OUT_W  golden-model output for the same operands
_busy  out  1  high in RUN or DRAIN
_done  out  1  high in DONE; held until next accepted start or reset
_pass  out  1  valid while _done: 1 iff _err_cnt==0
_err_cnt  out  2*WIDTH+1  mismatch count for the current/last sweep
_fail_valid  out  1  first-failure capture valid
_fail_a  out  WIDTH  operand A of first failing vector
_fail_b  out  WIDTH  operand B of first failing vector

Behaviour:
Interface:
- One clock, _clk.
- _rst_n is asynchronous assert, active-low. Deassertion is synchronized externally.

Reset values:
- State IDLE; vector index = 0.
- _a=0, _b=0, _busy=0, _done=0, _pass=0, _err_cnt=0, _fail_valid=0, _fail_a=0, _fail_b=0.

Vector order:
- N = 2^(2*WIDTH). Index idx has 2*WIDTH bits.
- _a = idx[WIDTH-1:0] (fastest-toggling), _b = idx[2*WIDTH-1:WIDTH].
- _a/_b are registered outputs.

FSM states and transitions:
- IDLE: _start=1 at edge E0 moves to RUN. On the same edge: idx=0, err_cnt cleared, fail_valid cleared, _done=0.
- RUN: vector k is driven during cycle k after E0. idx increments each edge. At the edge where idx==N-1: to DRAIN if LATENCY>0, else to DONE.
- DRAIN: lasts LATENCY cycles, then moves to DONE. _a/_b hold the last vector.
- DONE: _start=1 starts a new sweep exactly as from IDLE.
- _start while busy (RUN/DRAIN) is ignored.

Compare timing:
- A tag (valid, a, b) is shifted through a LATENCY-stage delay line.
- Vector k is compared at edge E0+k+1+LATENCY: _dut_y != _ref_y gives err_cnt+1.
- On the first mismatch: capture _fail_a/_fail_b and set _fail_valid.
- Comparison is bit-exact over all OUT_W bits.

Completion and counter width:
- _done rises at edge E0+N+LATENCY, the same edge as the final compare; that final compare is included in err_cnt and _pass.
- err_cnt width 2*WIDTH+1 holds N exactly, so no saturation logic is needed.

Boundaries:
- Reset mid-sweep aborts immediately to reset values. No partial results are retained.
- Restart from DONE clears all result outputs on the start edge.
- idx wrap from N-1 is never observed on _a/_b.

Decomposition:
- Shared package stim_chk_pkg: state enum (IDLE, RUN, DRAIN, DONE), 2-bit encoding; clog2 helper; localparam N computation function.
- One sub-module: tag_delay_line.
  - Parameters: DEPTH, W.
  - Shift register of {valid, a, b} with async active-low reset.
  - DEPTH=0 is a pass-through.

Test Plan:
1. WIDTH=1, OUT_W=1, LATENCY=0, ref=DUT=a|b; pulse _start -> _a/_b sequence (0,0),(1,0),(0,1),(1,1) on cycles 1-4; _done high after 4 edges; _pass=1; _err_cnt=0; _fail_valid=0.
2. Same configuration, DUT output stuck-at-0 -> _err_cnt=3, _pass=0, _fail_valid=1, _fail_a=1, _fail_b=0.
3. WIDTH=2, LATENCY=2, DUT = registered 2-stage a+b with correct reference -> 16 vectors, _done at edge 18 after start, _busy high for 18 cycles, _pass=1.
4. Start pulses at cycles 2 and 3 during RUN (case 1) -> ignored; sweep completes on the original schedule with identical results.
5. Assert _rst_n low asynchronously mid-RUN at vector 2 -> all outputs read reset values immediately; a new _start gives a full clean sweep.
6. After failing sweep (case 2), fix DUT and pulse _start in DONE -> results clear on the start edge; final _err_cnt=0, _fail_valid=0, _pass=1.

Source files
------------

// File: rtl/exhaustive_stim_checker_pkg.sv
// stim_chk_pkg: shared FSM encoding and sizing helpers for the exhaustive stimulus checker
package stim_chk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int unsigned num_vectors(input int w);
        return 32'd1 << (2 * w);
    endfunction

endpackage

// File: rtl/exhaustive_stim_checker_if.sv
// exhaustive_stim_checker_if: operand/response bus between the checker and its DUT plus reference
interface exhaustive_stim_checker_if #(
    parameter int WIDTH = 1,
    parameter int OUT_W = 1
) ();
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [OUT_W-1:0]     dut_y;
    logic [OUT_W-1:0]     ref_y;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2*WIDTH:0]     err_cnt;
    logic                 fail_valid;
    logic [WIDTH-1:0]     fail_a;
    logic [WIDTH-1:0]     fail_b;

    modport master (
        input  start, dut_y, ref_y,
        output a, b, busy, done, pass, err_cnt, fail_valid, fail_a, fail_b
    );

    modport slave (
        output start, dut_y, ref_y,
        input  a, b, busy, done, pass, err_cnt, fail_valid, fail_a, fail_b
    );
endinterface

// File: rtl/exhaustive_stim_checker_tag_delay_line.sv
// tag_delay_line: DEPTH-stage shift register aligning vector tags with the DUT pipeline
module tag_delay_line #(
    parameter int DEPTH = 0,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] tag_i,
    output logic [W-1:0] tag_o
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic unused;
            assign unused = clk_i ^ rst_ni;
            assign tag_o  = tag_i;
        end else begin : g_sr
            logic [W-1:0] sr_q [DEPTH];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
                end else begin
                    sr_q[0] <= tag_i;
                    for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
                end
            end
            assign tag_o = sr_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/exhaustive_stim_checker.sv
// exhaustive_stim_checker: sweeps every operand pair into a DUT and scores it against a reference
module exhaustive_stim_checker
    import stim_chk_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int OUT_W   = 1,
    parameter int LATENCY = 0
) (
    input logic clk_i,
    input logic rst_ni,
    exhaustive_stim_checker_if.master bus
);
    localparam int IW = 2 * WIDTH;
    localparam int CW = IW + 1;
    localparam int DW = (clog2(LATENCY + 1) > 0) ? clog2(LATENCY + 1) : 1;
    localparam int unsigned N = num_vectors(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_e           state_q;
    logic [IW-1:0]    idx_q;
    logic [DW-1:0]    drn_q;
    logic [CW-1:0]    err_q;
    logic             fv_q;
    logic [WIDTH-1:0] fa_q;
    logic [WIDTH-1:0] fb_q;
    logic [IW:0]      tag_in;
    logic [IW:0]      tag_out;
    logic             start_ok;
    logic             miss;

    // the tag carries the vector index so the compare knows which operands it belongs to
    assign tag_in   = {state_q == RUN, idx_q};
    assign start_ok = bus.start && (state_q == IDLE || state_q == DONE);
    assign miss     = tag_out[IW] && (bus.dut_y != bus.ref_y);

    tag_delay_line #(.DEPTH(LATENCY), .W(IW + 1)) u_tag (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drn_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: if (bus.start) begin
                    state_q <= RUN;
                    idx_q   <= '0;
                end
                RUN: if (idx_q == LAST) begin
                    if (LATENCY > 0) state_q <= DRAIN;
                    else             state_q <= DONE;
                    drn_q <= '0;
                end else begin
                    idx_q <= idx_q + IW'(1);
                end
                DRAIN: if (drn_q == DW'(LATENCY - 1)) state_q <= DONE;
                       else drn_q <= drn_q + DW'(1);
                default: state_q <= IDLE;
            endcase
            // no tag is in flight when a start is accepted, so clearing cannot drop a compare
            if (start_ok) begin
                err_q <= '0;
                fv_q  <= 1'b0;
                fa_q  <= '0;
                fb_q  <= '0;
            end else if (miss) begin
                err_q <= err_q + CW'(1);
                if (!fv_q) begin
                    fv_q <= 1'b1;
                    fa_q <= tag_out[WIDTH-1:0];
                    fb_q <= tag_out[IW-1:WIDTH];
                end
            end
        end
    end

    assign bus.a          = idx_q[WIDTH-1:0];
    assign bus.b          = idx_q[IW-1:WIDTH];
    assign bus.busy       = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done       = state_q == DONE;
    assign bus.pass       = (state_q == DONE) && (err_q == '0);
    assign bus.err_cnt    = err_q;
    assign bus.fail_valid = fv_q;
    assign bus.fail_a     = fa_q;
    assign bus.fail_b     = fb_q;
endmodule

// File: tb/tb_exhaustive_stim_checker.sv
// tb_exhaustive_stim_checker: directed checks of a 1-bit OR sweep and a 2-bit pipelined adder sweep
module tb_exhaustive_stim_checker;
    logic clk = 1'b0;
    logic rst_n;
    logic stuck;
    int   vecs = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    exhaustive_stim_checker_if #(.WIDTH(1), .OUT_W(1)) if1 ();
    exhaustive_stim_checker_if #(.WIDTH(2), .OUT_W(3)) if2 ();

    exhaustive_stim_checker #(.WIDTH(1), .OUT_W(1), .LATENCY(0)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1.master));
    exhaustive_stim_checker #(.WIDTH(2), .OUT_W(3), .LATENCY(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if2.master));

    assign if1.ref_y = if1.a | if1.b;
    assign if1.dut_y = stuck ? 1'b0 : (if1.a | if1.b);

    // DUT sums then delays; reference delays the operands then sums
    logic [2:0] s1 = '0, s2 = '0;
    logic [1:0] ra1 = '0, ra2 = '0, rb1 = '0, rb2 = '0;
    always_ff @(posedge clk) begin
        s1  <= {1'b0, if2.a} + {1'b0, if2.b};
        s2  <= s1;
        ra1 <= if2.a;
        ra2 <= ra1;
        rb1 <= if2.b;
        rb2 <= rb1;
    end
    assign if2.dut_y = s2;
    assign if2.ref_y = {1'b0, ra2} + {1'b0, rb2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_vals1(input string tag);
        chk({tag, " a"}, 32'(if1.a), 0);
        chk({tag, " b"}, 32'(if1.b), 0);
        chk({tag, " busy"}, 32'(if1.busy), 0);
        chk({tag, " done"}, 32'(if1.done), 0);
        chk({tag, " pass"}, 32'(if1.pass), 0);
        chk({tag, " err"}, 32'(if1.err_cnt), 0);
        chk({tag, " fv"}, 32'(if1.fail_valid), 0);
        chk({tag, " fa"}, 32'(if1.fail_a), 0);
        chk({tag, " fb"}, 32'(if1.fail_b), 0);
    endtask

    task automatic pulse1();
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
    endtask

    task automatic run1(input string tag, input int e, input int fv, input int fa, input int fb);
        pulse1();
        chk({tag, " start busy"}, 32'(if1.busy), 1);
        chk({tag, " start done"}, 32'(if1.done), 0);
        chk({tag, " start err"}, 32'(if1.err_cnt), 0);
        chk({tag, " start fv"}, 32'(if1.fail_valid), 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s a%0d", tag, k), 32'(if1.a), k & 1);
            chk($sformatf("%s b%0d", tag, k), 32'(if1.b), k >> 1);
            @(negedge clk);
        end
        chk({tag, " done"}, 32'(if1.done), 1);
        chk({tag, " busy"}, 32'(if1.busy), 0);
        chk({tag, " err"}, 32'(if1.err_cnt), e);
        chk({tag, " pass"}, 32'(if1.pass), e == 0 ? 1 : 0);
        chk({tag, " fv"}, 32'(if1.fail_valid), fv);
        chk({tag, " fa"}, 32'(if1.fail_a), fa);
        chk({tag, " fb"}, 32'(if1.fail_b), fb);
        chk({tag, " hold a"}, 32'(if1.a), 1);
        chk({tag, " hold b"}, 32'(if1.b), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        stuck = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
        repeat (2) @(negedge clk);
        reset_vals1("rst");
        chk("rst u2 busy", 32'(if2.busy), 0);
        chk("rst u2 done", 32'(if2.done), 0);
        chk("rst u2 err", 32'(if2.err_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run1("or_ok", 0, 0, 0, 0);

        if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("add busy%0d", i), 32'(if2.busy), 1);
            chk($sformatf("add done%0d", i), 32'(if2.done), 0);
            chk($sformatf("add a%0d", i), 32'(if2.a), i < 16 ? (i & 3) : 3);
            chk($sformatf("add b%0d", i), 32'(if2.b), i < 16 ? (i >> 2) : 3);
            @(negedge clk);
        end
        chk("add done", 32'(if2.done), 1);
        chk("add busy", 32'(if2.busy), 0);
        chk("add pass", 32'(if2.pass), 1);
        chk("add err", 32'(if2.err_cnt), 0);
        chk("add fv", 32'(if2.fail_valid), 0);

        stuck = 1'b1;
        run1("stuck0", 3, 1, 1, 0);
        stuck = 1'b0;
        run1("restart", 0, 0, 0, 0);

        pulse1();
        chk("ign a0", 32'(if1.a), 0);
        if1.start = 1'b1;
        @(negedge clk);
        chk("ign a1", 32'(if1.a), 1);
        chk("ign b1", 32'(if1.b), 0);
        @(negedge clk);
        if1.start = 1'b0;
        chk("ign a2", 32'(if1.a), 0);
        chk("ign b2", 32'(if1.b), 1);
        @(negedge clk);
        chk("ign a3", 32'(if1.a), 1);
        chk("ign b3", 32'(if1.b), 1);
        chk("ign busy3", 32'(if1.busy), 1);
        @(negedge clk);
        chk("ign done", 32'(if1.done), 1);
        chk("ign pass", 32'(if1.pass), 1);
        chk("ign err", 32'(if1.err_cnt), 0);
        @(negedge clk);
        chk("ign held done", 32'(if1.done), 1);
        chk("ign held a", 32'(if1.a), 1);

        pulse1();
        @(negedge clk);
        @(negedge clk);
        chk("abort a2", 32'(if1.a), 0);
        chk("abort b2", 32'(if1.b), 1);
        #2 rst_n = 1'b0;
        #1;
        reset_vals1("abort");
        chk("abort u2 done", 32'(if2.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run1("post_rst", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
